pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_if.sv | 47 ++++
 rtl/pipeline_ctrl.sv | 109 ++++++++++
 tb/tb_pipeline_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bundle.
// Carries the hazard-detection inputs from the pipeline and the stage control
// outputs back to it.
//   master : pipeline side (drives hazard inputs, receives stage controls)
//   slave  : controller side (receives hazard inputs, drives stage controls)
interface pipeline_ctrl_if;
   // Hazard inputs
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_uses_rs2;
   logic        ex_memread;
   logic [4:0]  ex_rd;
   logic        mem_branch_taken;
   logic        mem_memread;
   logic        mem_memwrite;
   logic        dmem_ready;
   // Stage controls
   logic        pc_en;
   logic        ifid_en;
   logic        idex_en;
   logic        exmem_en;
   logic        memwb_en;
   logic        ifid_flush;
   logic        exmem_flush;
   logic        idex_bubble;
   logic        memwb_bubble;
   logic        dmem_req;
   logic [1:0]  state;
   logic [15:0] stall_count;
   logic [15:0] flush_count;

   modport master (
      output id_rs1, id_rs2, id_uses_rs2, ex_memread, ex_rd,
             mem_branch_taken, mem_memread, mem_memwrite, dmem_ready,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, exmem_flush, idex_bubble, memwb_bubble,
             dmem_req, state, stall_count, flush_count
   );

   modport slave (
      input  id_rs1, id_rs2, id_uses_rs2, ex_memread, ex_rd,
             mem_branch_taken, mem_memread, mem_memwrite, dmem_ready,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, exmem_flush, idex_bubble, memwb_bubble,
             dmem_req, state, stall_count, flush_count
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller.
// Resolves memory wait, taken branch and load-use hazards in that priority
// order, producing per-stage load enables, flush/bubble controls and the data
// memory request, plus saturating stall and flush counters.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : pipeline_ctrl_if.slave (hazard inputs in, stage controls out)
module pipeline_ctrl (
   input logic            clock,
   input logic            reset,
   pipeline_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StLdStall = 2'd1,
      StFlush   = 2'd2,
      StMemWait = 2'd3
   } state_e;

   localparam logic [15:0] CountMax = 16'hFFFF;

   state_e      state_q, state_d;
   logic [15:0] stall_count_q;
   logic [15:0] flush_count_q;
   logic        memacc;
   logic        loaduse;
   logic        flush_fire;

   assign memacc  = bus.mem_memread | bus.mem_memwrite;
   // Register 31 is XZR: a load targeting it never creates a dependency.
   assign loaduse = bus.ex_memread & (bus.ex_rd != 5'd31) &
                    ((bus.ex_rd == bus.id_rs1) |
                     (bus.id_uses_rs2 & (bus.ex_rd == bus.id_rs2)));

   always_comb begin
      bus.pc_en        = 1'b1;
      bus.ifid_en      = 1'b1;
      bus.idex_en      = 1'b1;
      bus.exmem_en     = 1'b1;
      bus.memwb_en     = 1'b1;
      bus.ifid_flush   = 1'b0;
      bus.exmem_flush  = 1'b0;
      bus.idex_bubble  = 1'b0;
      bus.memwb_bubble = 1'b0;
      bus.dmem_req     = 1'b0;
      flush_fire       = 1'b0;
      state_d          = StRun;

      if (reset) begin
         bus.pc_en        = 1'b0;
         bus.ifid_en      = 1'b0;
         bus.idex_en      = 1'b0;
         bus.exmem_en     = 1'b0;
         bus.memwb_en     = 1'b0;
         bus.ifid_flush   = 1'b1;
         bus.exmem_flush  = 1'b1;
         bus.idex_bubble  = 1'b1;
         bus.memwb_bubble = 1'b1;
      end else begin
         bus.dmem_req = memacc;
         if (memacc && !bus.dmem_ready) begin
            // Freeze everything up to MEM; a coincident branch stays in
            // EX/MEM and is taken once the access completes.
            bus.pc_en        = 1'b0;
            bus.ifid_en      = 1'b0;
            bus.idex_en      = 1'b0;
            bus.exmem_en     = 1'b0;
            bus.memwb_bubble = 1'b1;
            state_d          = StMemWait;
         end else if (bus.mem_branch_taken) begin
            bus.ifid_flush  = 1'b1;
            bus.idex_bubble = 1'b1;
            bus.exmem_flush = 1'b1;
            flush_fire      = 1'b1;
            state_d         = StFlush;
         end else if (loaduse && (state_q != StFlush)) begin
            // After a flush the ID instruction is a NOP, so its operands
            // cannot create a load-use dependency.
            bus.pc_en       = 1'b0;
            bus.ifid_en     = 1'b0;
            bus.idex_bubble = 1'b1;
            state_d         = StLdStall;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= StRun;
         stall_count_q <= 16'd0;
         flush_count_q <= 16'd0;
      end else begin
         state_q <= state_d;
         if (!bus.pc_en && (stall_count_q != CountMax)) begin
            stall_count_q <= stall_count_q + 16'd1;
         end
         if (flush_fire && (flush_count_q != CountMax)) begin
            flush_count_q <= flush_count_q + 16'd1;
         end
      end
   end

   assign bus.state       = state_q;
   assign bus.stall_count = stall_count_q;
   assign bus.flush_count = flush_count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized and directed bench for pipeline_ctrl against an outcome-level
// reference model (each cycle is classified as reset/freeze/flush/stall/normal
// and the expected control vector is looked up from that outcome).
module tb_pipeline_ctrl;

   logic clock = 1'b0;
   logic reset;
   int   chk_cnt = 0;
   int   err_cnt = 0;

   // Reference model state
   int   m_state = 0;
   int   m_stall = 0;
   int   m_flush = 0;

   pipeline_ctrl_if bus ();

   pipeline_ctrl dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input bit rst, input int rs1, input int rs2, input bit uses,
                         input bit exmr, input int exrd, input bit br, input bit mr,
                         input bit mw, input bit rdy);
      reset                = rst;
      bus.id_rs1           = 5'(rs1);
      bus.id_rs2           = 5'(rs2);
      bus.id_uses_rs2      = uses;
      bus.ex_memread       = exmr;
      bus.ex_rd            = 5'(exrd);
      bus.mem_branch_taken = br;
      bus.mem_memread      = mr;
      bus.mem_memwrite     = mw;
      bus.dmem_ready       = rdy;
   endtask

   // Outcome: 0 reset, 1 freeze, 2 flush, 3 load-use stall, 4 normal.
   // Vector order: pc,ifid,idex,exmem,memwb, ifid_fl,exmem_fl,idex_bb,memwb_bb, dmem_req
   task automatic model(output logic [9:0] vec, output int nxt, output int outcome);
      bit acc;
      bit dep;
      acc = bus.mem_memread || bus.mem_memwrite;
      dep = bus.ex_memread && (int'(bus.ex_rd) != 31) &&
            (bus.ex_rd == bus.id_rs1 || (bus.id_uses_rs2 && bus.ex_rd == bus.id_rs2));
      if (reset)                              outcome = 0;
      else if (acc && !bus.dmem_ready)        outcome = 1;
      else if (bus.mem_branch_taken)          outcome = 2;
      else if (dep && m_state != 2)           outcome = 3;
      else                                    outcome = 4;
      case (outcome)
         0:       begin vec = 10'b00000_1111_0; nxt = 0; end
         1:       begin vec = 10'b00001_0001_0; nxt = 3; end
         2:       begin vec = 10'b11111_1110_0; nxt = 2; end
         3:       begin vec = 10'b00111_0010_0; nxt = 1; end
         default: begin vec = 10'b11111_0000_0; nxt = 0; end
      endcase
      if (outcome != 0) vec[0] = acc;
   endtask

   // Called just after a falling edge with inputs applied; returns at the next
   // falling edge with the model advanced.
   task automatic step(input string tag);
      logic [9:0] exp_vec;
      logic [9:0] obs_vec;
      int nxt;
      int outcome;
      #1;
      model(exp_vec, nxt, outcome);
      obs_vec = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                 bus.ifid_flush, bus.exmem_flush, bus.idex_bubble, bus.memwb_bubble,
                 bus.dmem_req};
      check({tag, ".ctl"}, 32'(obs_vec), 32'(exp_vec));
      check({tag, ".state"}, 32'(bus.state), 32'(m_state));
      @(posedge clock);
      #1;
      if (outcome == 0) begin
         m_state = 0;
         m_stall = 0;
         m_flush = 0;
      end else begin
         m_state = nxt;
         if (!exp_vec[9]) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
         if (outcome == 2) m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
      end
      check({tag, ".stall"}, 32'(bus.stall_count), 32'(m_stall));
      check({tag, ".flush"}, 32'(bus.flush_count), 32'(m_flush));
      @(negedge clock);
   endtask

   task automatic rnd_in();
      int rs1, rs2, rd;
      bit mr, mw;
      rs1 = $urandom_range(0, 31);
      rs2 = $urandom_range(0, 31);
      case ($urandom_range(0, 3))
         0:       rd = rs1;
         1:       rd = rs2;
         2:       rd = 31;
         default: rd = $urandom_range(0, 31);
      endcase
      mr = ($urandom_range(0, 9) < 2);
      mw = !mr && ($urandom_range(0, 9) < 2);
      set_in(($urandom_range(0, 49) == 0), rs1, rs2, $urandom_range(0, 1),
             ($urandom_range(0, 9) < 5), rd, ($urandom_range(0, 9) < 2), mr, mw,
             ($urandom_range(0, 9) < 6));
   endtask

   initial begin
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      @(negedge clock);
      step("reset");
      step("reset2");

      // First cycle out of reset with no hazards
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step("run");
      check("run.pc_en", 32'(bus.pc_en), 32'd1);

      // Load-use on rs1
      set_in(0, 5, 0, 0, 1, 5, 0, 0, 0, 1);
      step("ldu");
      check("ldu.state", 32'(bus.state), 32'd1);
      check("ldu.stall", 32'(bus.stall_count), 32'd1);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step("ldu.rel");

      // XZR exemption
      set_in(0, 31, 31, 1, 1, 31, 0, 0, 0, 1);
      step("xzr");
      check("xzr.state", 32'(bus.state), 32'd0);

      // Taken branch, then a load-use that the flush masks
      set_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
      step("br");
      check("br.state", 32'(bus.state), 32'd2);
      check("br.flush", 32'(bus.flush_count), 32'd1);
      set_in(0, 7, 0, 0, 1, 7, 0, 0, 0, 1);
      step("br.mask");
      check("br.mask.state", 32'(bus.state), 32'd0);

      // Memory wait: three not-ready cycles then ready
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step("rst.mw");
      for (int i = 0; i < 3; i++) begin
         set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
         step("memwait");
         check("memwait.state", 32'(bus.state), 32'd3);
      end
      check("memwait.stall", 32'(bus.stall_count), 32'd3);
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      step("memwait.rdy");
      check("memwait.rdy.state", 32'(bus.state), 32'd0);

      // Store wait coinciding with a taken branch
      set_in(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
      step("both");
      check("both.flush", 32'(bus.flush_count), 32'd0);
      set_in(0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
      step("both.rdy");
      check("both.rdy.flush", 32'(bus.flush_count), 32'd1);
      check("both.rdy.state", 32'(bus.state), 32'd2);

      // Reset in the middle of a memory wait
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      step("mw2");
      set_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      step("mw2.rst");
      check("mw2.rst.state", 32'(bus.state), 32'd0);
      check("mw2.rst.stall", 32'(bus.stall_count), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         rnd_in();
         step("rnd");
      end

      // Stall counter saturation: a long continuous load-use stall
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step("sat.rst");
      set_in(0, 9, 0, 0, 1, 9, 0, 0, 0, 1);
      step("sat.first");
      repeat (65600) @(posedge clock);
      @(negedge clock);
      m_state = 1;
      m_stall = 65535;
      check("sat.hold", 32'(bus.stall_count), 32'hFFFF);
      step("sat.more");
      check("sat.final", 32'(bus.stall_count), 32'hFFFF);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
